// File: rtl/piano_pkg.sv
// Shared piano constants and types.
// Contents: the REST note code, default recorder dimensions and the recorder
// state enum. Imported by note_ram and note_recorder.
package piano_pkg;

  localparam int NOTE_REST   = 0;     // note code 0 means "no key"
  localparam int LEN_DEF     = 4095;  // default maximum recordable beats
  localparam int BEAT_W_DEF  = 12;    // width of beat indices and lengths
  localparam int KEY_W_DEF   = 4;     // width of a note code

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_DONE = 2'd2
  } rec_state_e;

endpackage

// File: rtl/note_ram.sv
// Simple dual-port synchronous note RAM.
// One write port and one registered read port. On a same-address read and
// write in the same cycle, the read returns the old word. Contents are not
// reset.
// Ports:
//   clk        system clock
//   we_i       write enable
//   wr_addr_i  write beat index
//   wr_data_i  note code to store
//   rd_addr_i  read beat index
//   rd_data_o  registered read data (0 for indices outside the RAM)
module note_ram
  import piano_pkg::*;
#(
  parameter int LEN    = LEN_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [BEAT_W-1:0] wr_addr_i,
  input  logic [KEY_W-1:0]  wr_data_i,
  input  logic [BEAT_W-1:0] rd_addr_i,
  output logic [KEY_W-1:0]  rd_data_o
);

  localparam logic [BEAT_W-1:0] DEPTH = BEAT_W'(LEN);

  logic [KEY_W-1:0] mem_q [LEN];

  // Read samples the array before the write lands, giving old data on a
  // collision.
  always_ff @(posedge clk) begin
    if (we_i && (wr_addr_i < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_addr_i < DEPTH) begin
      rd_data_o <= mem_q[rd_addr_i];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule

// File: rtl/note_recorder.sv
// Note recorder: write-side counterpart of the beat sequencer.
// In record mode it samples the key input once per beat tick and stores one
// note code per beat into note_ram. A registered read port, indexed by beat,
// lets playback replay the take; indices at or beyond rec_len read as REST.
// Optional build macro LOOP_REC_EN: recording wraps at LEN beats and keeps
// overwriting the oldest beats until rec_stop; rec_len saturates at LEN.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   beat_tick  one-cycle strobe at beat rate
//   rec_start  pulse: clear the take and record from beat 0
//   rec_stop   pulse: end recording
//   key_valid  a key is currently pressed
//   key_code   code of the pressed key
//   rd_beat    playback read index
//   rd_note    note at rd_beat, one cycle later
//   rec_len    number of beats in the current take
//   recording  high while recording
//   rec_full   the take reached LEN beats
module note_recorder
  import piano_pkg::*;
#(
  parameter int LEN    = LEN_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat_tick,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic [KEY_W-1:0]  rd_note,
  output logic [BEAT_W-1:0] rec_len,
  output logic              recording,
  output logic              rec_full
);

  localparam logic [BEAT_W-1:0] LEN_B  = BEAT_W'(LEN);
  localparam logic [BEAT_W-1:0] LAST_B = BEAT_W'(LEN - 1);
  localparam logic [KEY_W-1:0]  REST   = KEY_W'(NOTE_REST);

  rec_state_e        state_q, state_d;
  logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
  logic [BEAT_W-1:0] rec_len_q, rec_len_d;
  logic              rec_full_q, rec_full_d;
  logic [KEY_W-1:0]  latch_q, latch_d;
  logic              mask_q;
  logic              we;
  logic [KEY_W-1:0]  wr_note;
  logic [KEY_W-1:0]  ram_rd;

  note_ram #(
    .LEN    (LEN),
    .KEY_W  (KEY_W),
    .BEAT_W (BEAT_W)
  ) u_ram (
    .clk       (clk),
    .we_i      (we),
    .wr_addr_i (wr_beat_q),
    .wr_data_i (wr_note),
    .rd_addr_i (rd_beat),
    .rd_data_o (ram_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_beat_q  <= '0;
      rec_len_q  <= '0;
      rec_full_q <= 1'b0;
      latch_q    <= REST;
      mask_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_beat_q  <= wr_beat_d;
      rec_len_q  <= rec_len_d;
      rec_full_q <= rec_full_d;
      latch_q    <= latch_d;
      // Mask decision uses the pre-write length, matching the RAM's
      // read-old-data behaviour on a collision.
      mask_q     <= (rd_beat >= rec_len_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_beat_d  = wr_beat_q;
    rec_len_d  = rec_len_q;
    rec_full_d = rec_full_q;
    latch_d    = latch_q;
    we         = 1'b0;
    // A press on the tick cycle itself beats anything latched earlier.
    wr_note    = key_valid ? key_code : latch_q;

    case (state_q)
      ST_REC: begin
        if (rec_start) begin
          // Restart discards any write that would have happened this cycle.
          wr_beat_d  = '0;
          rec_len_d  = '0;
          rec_full_d = 1'b0;
          latch_d    = REST;
        end else begin
          if (beat_tick) begin
            we      = 1'b1;
            latch_d = REST;
            if (wr_beat_q == LAST_B) begin
              wr_beat_d  = '0;
              rec_len_d  = LEN_B;
              rec_full_d = 1'b1;
`ifdef LOOP_REC_EN
              state_d    = ST_REC;
`else
              state_d    = ST_DONE;
`endif
            end else begin
              wr_beat_d = wr_beat_q + 1'b1;
`ifdef LOOP_REC_EN
              // Once wrapped, the take length stays pinned at LEN.
              rec_len_d = rec_full_q ? LEN_B : (wr_beat_q + 1'b1);
`else
              rec_len_d = wr_beat_q + 1'b1;
`endif
            end
          end else if (key_valid) begin
            latch_d = key_code;
          end
          // The tick's write (if any) still completes before leaving REC.
          if (rec_stop) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (rec_start) begin
          state_d    = ST_REC;
          wr_beat_d  = '0;
          rec_len_d  = '0;
          rec_full_d = 1'b0;
          latch_d    = REST;
        end
      end
    endcase
  end

  assign rd_note   = mask_q ? REST : ram_rd;
  assign rec_len   = rec_len_q;
  assign recording = (state_q == ST_REC);
  assign rec_full  = rec_full_q;

endmodule
